// File: rtl/bit_serializer.sv
// Parallel-to-serial stimulus stage: words in over valid/ready, one bit out on x_out per bit_en strobe.
// Latency: the first bit is on x_out one edge after the accepting handshake; with GAP=0 words stream back-to-back with no bubble.
// Backpressure: a one-word hold buffer; in_ready drops while it is full; bit_en=0 freezes the stream indefinitely.
// Ports: clk/reset (sync, active-low); in_data/in_valid/in_ready word input;
//        bit_en shift strobe; x_out/x_valid registered serial output;
//        busy (active or word pending); word_done (pulse when a word's last bit is consumed).
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shift_reg, shift_reg_d;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic [WIDTH-1:0] hold_data, hold_data_d;
    logic             hold_full, hold_full_d;
    logic             x_out_d, x_valid_d, word_done_d;

    logic             xfer;
    logic             word_end;
    logic             do_load;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shifted;

    // The bit presented on x_out is always the "first" position of the shift register.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    assign in_ready = !hold_full;
    assign busy     = (state != S_IDLE) || hold_full;
    assign xfer     = in_valid && !hold_full;
    assign shifted  = (LSB_FIRST != 0) ? (shift_reg >> 1) : (shift_reg << 1);

    always_comb begin
        state_d     = state;
        shift_reg_d = shift_reg;
        bit_cnt_d   = bit_cnt;
        gap_cnt_d   = gap_cnt;
        hold_data_d = hold_data;
        hold_full_d = hold_full;
        x_out_d     = x_out;
        x_valid_d   = x_valid;
        word_done_d = 1'b0;
        word_end    = 1'b0;
        do_load     = 1'b0;
        load_word   = in_data;

        case (state)
            S_IDLE: begin
                if (xfer) begin
                    do_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_en) begin
                    if (bit_cnt == LAST_BIT) begin
                        word_done_d = 1'b1;
                        if (GAP > 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                            x_valid_d = 1'b0;
                            x_out_d   = 1'b0;
                        end else begin
                            word_end = 1'b1;
                        end
                    end else begin
                        shift_reg_d = shifted;
                        x_out_d     = first_bit(shifted);
                        bit_cnt_d   = bit_cnt + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (bit_en) begin
                    // The final idle tick goes straight to the load-or-idle decision.
                    if (gap_cnt == LAST_GAP) begin
                        word_end = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // End of a word (or its gap): the hold buffer has priority; an empty
        // buffer lets a same-edge handshake bypass straight into shift_reg.
        if (word_end) begin
            if (hold_full) begin
                do_load     = 1'b1;
                load_word   = hold_data;
                hold_full_d = 1'b0;
            end else if (xfer) begin
                do_load = 1'b1;
            end else begin
                state_d   = S_IDLE;
                x_valid_d = 1'b0;
                x_out_d   = 1'b0;
            end
        end else if (xfer && (state != S_IDLE)) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
        end

        if (do_load) begin
            shift_reg_d = load_word;
            bit_cnt_d   = '0;
            x_out_d     = first_bit(load_word);
            x_valid_d   = 1'b1;
            state_d     = S_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            x_out     <= 1'b0;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_d;
            shift_reg <= shift_reg_d;
            bit_cnt   <= bit_cnt_d;
            gap_cnt   <= gap_cnt_d;
            hold_data <= hold_data_d;
            hold_full <= hold_full_d;
            x_out     <= x_out_d;
            x_valid   <= x_valid_d;
            word_done <= word_done_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: instance 0 is MSB-first with no gap, instance 1 is
// LSB-first with a 2-tick gap. A queue-level reference model predicts every
// output each cycle; directed steps also check the consumed bit streams.
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst;
    logic [1:0]      in_valid;
    logic [1:0]      bit_en;
    logic [1:0][7:0] in_data;
    wire  [1:0]      in_ready;
    wire  [1:0]      x_out;
    wire  [1:0]      x_valid;
    wire  [1:0]      busy;
    wire  [1:0]      word_done;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP(0)) u_msb (
        .clk(clk), .reset(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .bit_en(bit_en[0]), .x_out(x_out[0]),
        .x_valid(x_valid[0]), .busy(busy[0]), .word_done(word_done[0])
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP(2)) u_lsb (
        .clk(clk), .reset(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .bit_en(bit_en[1]), .x_out(x_out[1]),
        .x_valid(x_valid[1]), .busy(busy[1]), .word_done(word_done[1])
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Words waiting to be offered, per instance.
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    int         en_mode[2];   // 0: always, 1: every 4th cycle, 2: random, 3: never

    // Reference model: the current word and how many of its bits remain,
    // remaining idle ticks, and the one pending word.
    logic [7:0] m_word[2];
    int         m_left[2];
    int         m_gap[2];
    bit         m_hv[2];
    logic [7:0] m_hw[2];
    bit         m_done[2];

    // Observed stream: bits the consumer sampled, valid cycles, done pulses.
    logic [31:0] log_bits[2];
    int          log_n[2];
    int          vcnt[2];
    int          dcnt[2];

    function automatic int gap_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic bit lsb_of(input int k);
        return (k == 1);
    endfunction

    function automatic int fq_size(input int k);
        return (k == 0) ? fq0.size() : fq1.size();
    endfunction

    function automatic logic [7:0] fq_front(input int k);
        return (k == 0) ? fq0[0] : fq1[0];
    endfunction

    task automatic fq_push(input int k, input logic [7:0] w);
        if (k == 0) fq0.push_back(w);
        else        fq1.push_back(w);
    endtask

    task automatic fq_pop(input int k);
        if (k == 0) void'(fq0.pop_front());
        else        void'(fq1.pop_front());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_logs(input int k);
        log_bits[k] = '0;
        log_n[k]    = 0;
        vcnt[k]     = 0;
        dcnt[k]     = 0;
    endtask

    task automatic model_update(input int k);
        bit xfer;
        bit start;
        xfer      = rst[k] && in_valid[k] && !m_hv[k];
        start     = 1'b0;
        m_done[k] = 1'b0;
        if (xfer) fq_pop(k);
        if (!rst[k]) begin
            m_left[k] = 0;
            m_gap[k]  = 0;
            m_hv[k]   = 1'b0;
        end else if (m_left[k] == 0 && m_gap[k] == 0) begin
            if (xfer) begin
                m_word[k] = in_data[k];
                m_left[k] = 8;
            end
        end else begin
            // Incoming word joins the pending slot; a word ending this edge may take it at once.
            if (xfer) begin
                m_hv[k] = 1'b1;
                m_hw[k] = in_data[k];
            end
            if (m_left[k] > 0) begin
                if (bit_en[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_done[k] = 1'b1;
                        if (gap_of(k) > 0) m_gap[k] = gap_of(k);
                        else               start = 1'b1;
                    end
                end
            end else if (bit_en[k]) begin
                m_gap[k]--;
                if (m_gap[k] == 0) start = 1'b1;
            end
            if (start && m_hv[k]) begin
                m_word[k] = m_hw[k];
                m_left[k] = 8;
                m_hv[k]   = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input int k);
        logic ev;
        logic eb;
        int   idx;
        ev = (m_left[k] > 0);
        eb = 1'b0;
        if (ev) begin
            idx = lsb_of(k) ? (8 - m_left[k]) : (m_left[k] - 1);
            eb  = m_word[k][idx];
        end
        chk($sformatf("x_valid[%0d] cyc%0d", k, cyc), 32'(x_valid[k]), 32'(ev));
        chk($sformatf("x_out[%0d] cyc%0d", k, cyc), 32'(x_out[k]), 32'(eb));
        chk($sformatf("in_ready[%0d] cyc%0d", k, cyc), 32'(in_ready[k]), 32'(!m_hv[k]));
        chk($sformatf("busy[%0d] cyc%0d", k, cyc), 32'(busy[k]),
            32'((m_left[k] > 0) || (m_gap[k] > 0) || m_hv[k]));
        chk($sformatf("word_done[%0d] cyc%0d", k, cyc), 32'(word_done[k]), 32'(m_done[k]));
    endtask

    task automatic step();
        cyc++;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = (fq_size(k) > 0);
            in_data[k]  = in_valid[k] ? fq_front(k) : 8'h00;
            case (en_mode[k])
                0:       bit_en[k] = 1'b1;
                1:       bit_en[k] = ((cyc % 4) == 0);
                2:       bit_en[k] = 1'($urandom_range(0, 1));
                default: bit_en[k] = 1'b0;
            endcase
            if (x_valid[k] === 1'b1) vcnt[k]++;
            if (x_valid[k] === 1'b1 && bit_en[k]) begin
                log_bits[k] = {log_bits[k][30:0], x_out[k]};
                log_n[k]++;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (word_done[k] === 1'b1) dcnt[k]++;
            check_outputs(k);
        end
    endtask

    task automatic run_until_idle(input int k, input int budget);
        int n;
        n = 0;
        while ((m_left[k] > 0 || m_gap[k] > 0 || m_hv[k] || fq_size(k) > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            $error("FAIL timeout[%0d] observed=busy after %0d cycles expected=idle", k, n);
        end
    endtask

    initial begin
        rst      = 2'b00;
        in_valid = 2'b00;
        bit_en   = 2'b00;
        in_data  = '0;
        for (int k = 0; k < 2; k++) begin
            en_mode[k] = 0;
            m_word[k]  = '0;
            m_left[k]  = 0;
            m_gap[k]   = 0;
            m_hv[k]    = 1'b0;
            m_hw[k]    = '0;
            m_done[k]  = 1'b0;
            clear_logs(k);
        end

        // Reset held for two edges with a word offered: nothing loads.
        fq_push(0, 8'h6A);
        fq_push(1, 8'h6A);
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_x_valid[%0d]", k), 32'(x_valid[k]), 32'd0);
            chk($sformatf("rst_in_ready[%0d]", k), 32'(in_ready[k]), 32'd1);
            chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
        end
        fq0.delete();
        fq1.delete();
        rst = 2'b11;
        step();

        // Single word, MSB first, continuous strobe.
        clear_logs(0);
        fq_push(0, 8'h6A);
        run_until_idle(0, 50);
        chk("single_bits", 32'(log_n[0]), 32'd8);
        chk("single_word", log_bits[0], 32'h6A);
        chk("single_done", 32'(dcnt[0]), 32'd1);
        chk("single_valid", 32'(vcnt[0]), 32'd8);

        // Three words back to back: contiguous stream, third word stalls.
        clear_logs(0);
        fq_push(0, 8'h6A);
        fq_push(0, 8'hB3);
        fq_push(0, 8'h5C);
        run_until_idle(0, 100);
        chk("b2b_bits", 32'(log_n[0]), 32'd24);
        chk("b2b_stream", log_bits[0], 32'h006AB35C);
        chk("b2b_valid", 32'(vcnt[0]), 32'd24);
        chk("b2b_done", 32'(dcnt[0]), 32'd3);

        // Strobe every 4th cycle, loaded on a strobe cycle.
        en_mode[0] = 1;
        while (((cyc + 1) % 4) != 0) step();
        clear_logs(0);
        fq_push(0, 8'hF0);
        run_until_idle(0, 100);
        chk("slow_valid", 32'(vcnt[0]), 32'd32);
        chk("slow_done", 32'(dcnt[0]), 32'd1);
        chk("slow_word", log_bits[0], 32'hF0);
        en_mode[0] = 0;

        // LSB first with a 2-tick gap.
        clear_logs(1);
        fq_push(1, 8'h01);
        fq_push(1, 8'h80);
        run_until_idle(1, 100);
        chk("gap_bits", 32'(log_n[1]), 32'd16);
        chk("gap_stream", log_bits[1], 32'h00008001);
        chk("gap_valid", 32'(vcnt[1]), 32'd16);
        chk("gap_done", 32'(dcnt[1]), 32'd2);

        // Reset after three bits with a word held; it must be discarded.
        clear_logs(0);
        fq_push(0, 8'h6A);
        fq_push(0, 8'hFF);
        for (int n = 0; n < 20 && log_n[0] < 3; n++) step();
        chk("midrst_progress", 32'(log_n[0]), 32'd3);
        chk("midrst_held", 32'(in_ready[0]), 32'd0);
        rst[0] = 1'b0;
        fq0.delete();
        step();
        chk("midrst_x_valid", 32'(x_valid[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b1;
        clear_logs(0);
        fq_push(0, 8'h55);
        run_until_idle(0, 50);
        chk("midrst_bits", 32'(log_n[0]), 32'd8);
        chk("midrst_word", log_bits[0], 32'h55);

        // Random traffic, strobe patterns and occasional resets on both instances.
        for (int n = 0; n < 3000; n++) begin
            if ((n % 150) == 0) begin
                en_mode[0] = $urandom_range(0, 2);
                en_mode[1] = $urandom_range(0, 2);
            end
            for (int k = 0; k < 2; k++) begin
                if (fq_size(k) == 0 && $urandom_range(0, 2) == 0) fq_push(k, 8'($urandom));
                rst[k] = ($urandom_range(0, 299) != 0);
            end
            step();
        end
        rst = 2'b11;
        en_mode[0] = 0;
        en_mode[1] = 0;
        run_until_idle(0, 100);
        run_until_idle(1, 100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
